picorv32_mem_arbiter: RTL and testbench
=======================================

PICORV32_MEM_ARBITER -- requirements
Module: picorv32_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: the number of BUSY cycles without downstream mem_ready before the transfer is forcibly ended (range 1..65535).
REQ-002 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have ports mN_mem_valid and mN_mem_instr (N=0,1), input, 1 each: requester N native-port valid and instruction-fetch flag.
REQ-005 SHALL have ports mN_mem_addr and mN_mem_wdata, input, 32 each; and mN_mem_wstrb, input, 4: requester N address, write data and byte strobes.
REQ-006 SHALL have ports mN_mem_ready, output, 1; and mN_mem_rdata, output, 32: requester N completion and read data.
REQ-007 SHALL have ports mem_valid and mem_instr, output, 1; mem_addr and mem_wdata, output, 32; and mem_wstrb, output, 4: the shared downstream native port.
REQ-008 SHALL have ports mem_ready, input, 1; and mem_rdata, input, 32: downstream completion and read data.
REQ-009 SHALL have port grant, output, 1: the index of the current or most recent owner.
REQ-010 SHALL have port timeout_err, output, 1: a sticky flag set by a forced timeout.

Function
REQ-011 SHALL implement an FSM with states IDLE and BUSY and a registered owner bit.
REQ-012 SHALL, in IDLE with at least one mN_mem_valid high, register owner and enter BUSY on the next edge.
- Only one requester valid: that requester is chosen.
- Both valid: the requester that is not last_owner is chosen (round-robin).
REQ-013 SHALL assert mem_valid only in BUSY, giving a 1-cycle request-to-downstream latency.
REQ-014 SHALL, while in BUSY, drive mem_instr, mem_addr, mem_wdata and mem_wstrb combinationally from the owner's inputs; in IDLE these outputs SHALL be 0.
REQ-015 SHALL, in BUSY with mem_ready high, assert m<owner>_mem_ready in the same cycle, return to IDLE on the next edge and set last_owner to owner.
REQ-016 SHALL hold the non-owner's mN_mem_ready at 0 at all times; a requester's ready is never asserted while its valid is low.
REQ-017 SHALL route mem_rdata to both mN_mem_rdata outputs unconditionally; data is meaningful only with the matching ready.
REQ-018 SHALL make back-to-back transfers pass through one IDLE cycle, giving a minimum of 2 cycles per transfer.
- A continuously requesting pair alternates grants 0,1,0,1...
REQ-019 SHALL ignore an owner mN_mem_valid drop during BUSY; the FSM stays BUSY until ready or timeout.
REQ-020 SHALL drive grant as the registered owner; it holds its value through IDLE.

Reset
REQ-021 SHALL, while resetn is low at a clock edge, force state IDLE, owner 0, last_owner 1 (so requester 0 wins first), timeout counter 0 and timeout_err 0.
- All outputs SHALL be 0 during and after reset, except mN_mem_rdata, which follows mem_rdata.
REQ-022 SHALL, on reset asserted mid-transfer, abandon the transfer with no ready pulse to any requester.

Configuration
REQ-023 SHALL, with macro PICORV32_ARB_TIMEOUT_EN defined, implement the timeout behaviour:
- A 16-bit counter clears on entering BUSY and increments each BUSY cycle without mem_ready.
- When the counter equals TIMEOUT, the cycle SHALL assert m<owner>_mem_ready with mN_mem_rdata forced to 0 and mem_valid forced to 0.
- In that cycle timeout_err is set (sticky until reset) and the FSM returns to IDLE next edge.
- mem_ready high in the timeout cycle SHALL take precedence as a normal completion, with no error.
REQ-024 SHALL, without PICORV32_ARB_TIMEOUT_EN, have no counter, tie timeout_err to 0 and ignore TIMEOUT.

Structure
REQ-025 SHALL place the state typedef (ARB_IDLE, ARB_BUSY), the counter width constant (16) and the requester count (2) in package picorv32_arb_pkg.
REQ-026 SHALL be a single flat module; no sub-module is warranted.

Verification
REQ-027 SHALL cover single request: m0 read of 0x100 with mem_ready a cycle after mem_valid -> mem_valid at cycle 1; m0_mem_ready pulses at cycle 2 carrying mem_rdata 0xDEADBEEF; grant=0.
REQ-028 SHALL cover contention: m0 and m1 valid together after reset -> m0 served first, then m1; grants 0,1; m1_mem_ready never high during m0's transfer.
REQ-029 SHALL cover a write: m1 write of 0xA5A5A5A5 with wstrb 4'b0011 to 0x2000 -> downstream mem_addr=0x2000, mem_wdata=0xA5A5A5A5, mem_wstrb=4'b0011 for the whole of BUSY.
REQ-030 SHALL cover the timeout with the macro defined, TIMEOUT=4 and mem_ready held at 0 -> owner ready with rdata 0 at the 4th stalled BUSY cycle; timeout_err=1 and stays set.
REQ-031 SHALL cover reset mid-operation: resetn low during BUSY -> next cycle IDLE, mem_valid=0, no mN_mem_ready pulse, grant=0, timeout_err=0.
REQ-032 SHALL cover saturation: both requesters valid for 20 cycles -> 10 completions alternating 0,1,...

Source files
------------

// File: rtl/picorv32_arb_pkg.sv
// Shared types and constants for the two-requester PicoRV32 native-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package picorv32_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_CNT_W   = 16;
  localparam int ARB_NUM_REQ = 2;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } arb_req_t;

endpackage

// File: rtl/picorv32_mem_arbiter.sv
// Round-robin arbiter of two PicoRV32 native ports onto one; PICORV32_ARB_TIMEOUT_EN adds a stall timeout.
// Latency: request to downstream mem_valid 1 cycle, ready returned same cycle as mem_ready; min 2 cycles/transfer.
// Backpressure: owner holds the port until mem_ready (or timeout); the other requester waits with ready low.
module picorv32_mem_arbiter
  import picorv32_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        grant,
  output logic        timeout_err
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("picorv32_mem_arbiter: TIMEOUT must be in 1..65535");
  end

  arb_state_e state_q;
  logic       owner_q;
  logic       last_owner_q;
  arb_req_t   req0, req1, sel;
  logic       busy, pick, done, tmo_hit;

  assign req0 = {m0_mem_instr, m0_mem_addr, m0_mem_wdata, m0_mem_wstrb};
  assign req1 = {m1_mem_instr, m1_mem_addr, m1_mem_wdata, m1_mem_wstrb};
  assign sel  = owner_q ? req1 : req0;

  // Qualified with resetn so a reset cycle mid-transfer never leaks a ready or valid.
  assign busy = resetn && (state_q == ARB_BUSY);

`ifdef PICORV32_ARB_TIMEOUT_EN
  localparam logic [ARB_CNT_W-1:0] TMO_LAST = ARB_CNT_W'(TIMEOUT - 1);
  logic [ARB_CNT_W-1:0] cnt_q;
  logic                 timeout_err_q;

  // cnt_q counts stalls already seen, so this is the TIMEOUT-th stalled cycle.
  assign tmo_hit     = busy && !mem_ready && (cnt_q == TMO_LAST);
  assign timeout_err = resetn && timeout_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign done = busy && (mem_ready || tmo_hit);
  assign pick = (m0_mem_valid && m1_mem_valid) ? ~last_owner_q : m1_mem_valid;

  assign mem_valid = busy && !tmo_hit;
  assign {mem_instr, mem_addr, mem_wdata, mem_wstrb} = busy ? sel : '0;

  assign m0_mem_ready = done && !owner_q && m0_mem_valid;
  assign m1_mem_ready = done &&  owner_q && m1_mem_valid;
  assign m0_mem_rdata = tmo_hit ? '0 : mem_rdata;
  assign m1_mem_rdata = tmo_hit ? '0 : mem_rdata;
  assign grant        = resetn && owner_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ARB_IDLE;
      owner_q       <= 1'b0;
      last_owner_q  <= 1'b1;
`ifdef PICORV32_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (m0_mem_valid || m1_mem_valid) begin
            owner_q <= pick;
            state_q <= ARB_BUSY;
`ifdef PICORV32_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ARB_BUSY: begin
          if (done) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= owner_q;
`ifdef PICORV32_ARB_TIMEOUT_EN
            if (tmo_hit) timeout_err_q <= 1'b1;
`endif
          end
`ifdef PICORV32_ARB_TIMEOUT_EN
          else cnt_q <= cnt_q + ARB_CNT_W'(1);
`endif
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: transfer-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with sporadic resets.
module tb_picorv32_mem_arbiter;

  localparam int T = 4;
`ifdef PICORV32_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_mem_valid = 0, m0_mem_instr = 0, m1_mem_valid = 0, m1_mem_instr = 0;
  logic [31:0] m0_mem_addr = 0, m0_mem_wdata = 0, m1_mem_addr = 0, m1_mem_wdata = 0;
  logic [3:0]  m0_mem_wstrb = 0, m1_mem_wstrb = 0;
  logic        m0_mem_ready, m1_mem_ready;
  logic [31:0] m0_mem_rdata, m1_mem_rdata;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 0;
  logic [31:0] mem_rdata = 0;
  logic        grant, timeout_err;

  picorv32_mem_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .resetn(resetn),
    .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_addr(m0_mem_addr),
    .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb),
    .m0_mem_ready(m0_mem_ready), .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_addr(m1_mem_addr),
    .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb),
    .m1_mem_ready(m1_mem_ready), .m1_mem_rdata(m1_mem_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int comp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks one transfer at a time (who owns it, how long it has stalled).
  bit md_init = 0, md_busy = 0, md_owner = 0, md_last = 1, md_err = 0;
  int md_stall = 0;

  always @(negedge clk) begin
    bit tmo, fin, e_v, e_r0, e_r1, e_g, e_e;
    logic [68:0] e_req;
    logic [31:0] e_rd;
    tmo = 0; fin = 0; e_v = 0; e_r0 = 0; e_r1 = 0; e_g = 0; e_e = 0;
    e_req = '0;
    e_rd = mem_rdata;
    if (resetn && md_init) begin
      e_g = md_owner;
      e_e = md_err;
      if (md_busy) begin
        tmo  = TMO_EN && !mem_ready && (md_stall + 1 == T);
        fin  = mem_ready || tmo;
        e_v  = !tmo;
        e_req = md_owner ? {m1_mem_instr, m1_mem_addr, m1_mem_wdata, m1_mem_wstrb}
                         : {m0_mem_instr, m0_mem_addr, m0_mem_wdata, m0_mem_wstrb};
        e_r0 = fin && !md_owner && m0_mem_valid;
        e_r1 = fin &&  md_owner && m1_mem_valid;
        if (tmo) e_rd = 32'h0;
      end
    end
    if (!resetn || md_init) begin
      check("mem_valid", 32'(mem_valid), 32'(e_v));
      check("mem_instr", 32'(mem_instr), 32'(e_req[68]));
      check("mem_addr", mem_addr, e_req[67:36]);
      check("mem_wdata", mem_wdata, e_req[35:4]);
      check("mem_wstrb", 32'(mem_wstrb), 32'(e_req[3:0]));
      check("m0_ready", 32'(m0_mem_ready), 32'(e_r0));
      check("m1_ready", 32'(m1_mem_ready), 32'(e_r1));
      check("m0_rdata", m0_mem_rdata, e_rd);
      check("m1_rdata", m1_mem_rdata, e_rd);
      check("grant", 32'(grant), 32'(e_g));
      check("timeout_err", 32'(timeout_err), 32'(e_e));
    end
    if (m0_mem_ready) comp_q.push_back(0);
    if (m1_mem_ready) comp_q.push_back(1);

    if (!resetn) begin
      md_init = 1; md_busy = 0; md_owner = 0; md_last = 1; md_err = 0; md_stall = 0;
    end else if (md_init) begin
      if (!md_busy) begin
        if (m0_mem_valid || m1_mem_valid) begin
          md_owner = (m0_mem_valid && m1_mem_valid) ? !md_last : m1_mem_valid;
          md_busy  = 1;
          md_stall = 0;
        end
      end else if (fin) begin
        md_busy = 0;
        md_last = md_owner;
        md_err  = md_err | tmo;
      end else begin
        md_stall++;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_mem_valid = 0; m0_mem_instr = 0; m0_mem_addr = 0; m0_mem_wdata = 0; m0_mem_wstrb = 0;
    m1_mem_valid = 0; m1_mem_instr = 0; m1_mem_addr = 0; m1_mem_wdata = 0; m1_mem_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    nxt();
    clear_inputs();
    resetn = 0;
    nxt();
    nxt();
    resetn = 1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    check("rst_m0_ready", 32'(m0_mem_ready), 32'h0);
    nxt();
    resetn = 1;

    // Single read by m0
    nxt();
    m0_mem_valid = 1; m0_mem_addr = 32'h100;
    @(negedge clk);
    check("single_c0_valid", 32'(mem_valid), 32'h0);
    nxt();
    @(negedge clk);
    check("single_c1_valid", 32'(mem_valid), 32'h1);
    check("single_c1_addr", mem_addr, 32'h100);
    check("single_c1_m0_ready", 32'(m0_mem_ready), 32'h0);
    nxt();
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("single_c2_m0_ready", 32'(m0_mem_ready), 32'h1);
    check("single_c2_rdata", m0_mem_rdata, 32'hDEADBEEF);
    check("single_c2_grant", 32'(grant), 32'h0);
    nxt();
    m0_mem_valid = 0; mem_ready = 0;
    @(negedge clk);
    check("single_c3_valid", 32'(mem_valid), 32'h0);

    // Contention and saturation: both valid for 20 cycles
    do_reset();
    comp_q.delete();
    nxt();
    m0_mem_valid = 1; m0_mem_addr = 32'h40; m1_mem_valid = 1; m1_mem_addr = 32'h80; mem_ready = 1;
    repeat (19) nxt();
    nxt();
    clear_inputs();
    @(negedge clk);
    check("sat_count", 32'(comp_q.size()), 32'd10);
    for (int i = 0; i < comp_q.size() && i < 10; i++)
      check($sformatf("sat_order_%0d", i), 32'(comp_q[i]), 32'(i % 2));

    // Write by m1 with two stall cycles
    do_reset();
    nxt();
    m1_mem_valid = 1; m1_mem_addr = 32'h2000; m1_mem_wdata = 32'hA5A5A5A5; m1_mem_wstrb = 4'b0011;
    for (int k = 1; k <= 3; k++) begin
      nxt();
      if (k == 3) mem_ready = 1;
      @(negedge clk);
      check($sformatf("wr_valid_%0d", k), 32'(mem_valid), 32'h1);
      check($sformatf("wr_addr_%0d", k), mem_addr, 32'h2000);
      check($sformatf("wr_wdata_%0d", k), mem_wdata, 32'hA5A5A5A5);
      check($sformatf("wr_wstrb_%0d", k), 32'(mem_wstrb), 32'h3);
      check($sformatf("wr_m1_ready_%0d", k), 32'(m1_mem_ready), 32'(k == 3));
      check($sformatf("wr_grant_%0d", k), 32'(grant), 32'h1);
    end
    nxt();
    clear_inputs();

    // Stall: timeout when enabled, indefinite wait otherwise
    do_reset();
    nxt();
    m0_mem_valid = 1; mem_rdata = 32'h12345678;
`ifdef PICORV32_ARB_TIMEOUT_EN
    for (int k = 1; k <= T; k++) begin
      nxt();
      @(negedge clk);
      check($sformatf("tmo_m0_ready_%0d", k), 32'(m0_mem_ready), 32'(k == T));
      check($sformatf("tmo_valid_%0d", k), 32'(mem_valid), 32'(k != T));
    end
    check("tmo_rdata", m0_mem_rdata, 32'h0);
    check("tmo_err_set", 32'(timeout_err), 32'h1);
    nxt();
    m0_mem_valid = 0;
    repeat (3) nxt();
    @(negedge clk);
    check("tmo_err_sticky", 32'(timeout_err), 32'h1);
`else
    for (int k = 1; k <= 2 * T; k++) begin
      nxt();
      @(negedge clk);
      check($sformatf("stall_m0_ready_%0d", k), 32'(m0_mem_ready), 32'h0);
      check($sformatf("stall_valid_%0d", k), 32'(mem_valid), 32'h1);
    end
    check("stall_no_err", 32'(timeout_err), 32'h0);
    nxt();
    mem_ready = 1;
    nxt();
    m0_mem_valid = 0; mem_ready = 0;
`endif

    // Reset asserted mid-transfer
    nxt();
    m0_mem_valid = 1;
    nxt();
    @(negedge clk);
    check("rstmid_busy_valid", 32'(mem_valid), 32'h1);
    nxt();
    resetn = 0; mem_ready = 1;
    @(negedge clk);
    check("rstmid_no_ready", 32'(m0_mem_ready), 32'h0);
    check("rstmid_no_valid", 32'(mem_valid), 32'h0);
    nxt();
    resetn = 1; m0_mem_valid = 0; mem_ready = 0;
    @(negedge clk);
    check("rstmid_after_valid", 32'(mem_valid), 32'h0);
    check("rstmid_after_grant", 32'(grant), 32'h0);
    check("rstmid_after_err", 32'(timeout_err), 32'h0);
    check("rstmid_after_ready", 32'(m0_mem_ready), 32'h0);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      nxt();
      resetn       = ($urandom_range(0, 99) != 0);
      m0_mem_valid = ($urandom_range(0, 3) != 0);
      m1_mem_valid = ($urandom_range(0, 2) != 0);
      m0_mem_instr = 1'($urandom);
      m1_mem_instr = 1'($urandom);
      m0_mem_addr  = $urandom;
      m1_mem_addr  = $urandom;
      m0_mem_wdata = $urandom;
      m1_mem_wdata = $urandom;
      m0_mem_wstrb = 4'($urandom);
      m1_mem_wstrb = 4'($urandom);
      mem_ready    = ($urandom_range(0, 9) < 4);
      mem_rdata    = $urandom;
    end
    nxt();
    clear_inputs();
    resetn = 1;
    repeat (2) nxt();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
